// File: rtl/regfile_access_sequencer.sv
// Operand-fetch and writeback sequencer for a register file with registered
// read ports; bypasses a write that coincides with the read sample edge.
module regfile_access_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_readA_address,
    output logic [ADDR_W-1:0] rf_readB_address,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_value,
    input  logic [DATA_W-1:0] rf_reg_A,
    input  logic [DATA_W-1:0] rf_reg_B
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic accept_c;
    logic wb_fire_c;

    logic              byp_a;
    logic              byp_b;
    logic [DATA_W-1:0] byp_val_a;
    logic [DATA_W-1:0] byp_val_b;

    logic              rd_req_ready_next;
    logic              op_valid_next;
    logic [DATA_W-1:0] op_a_next;
    logic [DATA_W-1:0] op_b_next;
    logic [ADDR_W-1:0] rd_addr_a_next;
    logic [ADDR_W-1:0] rd_addr_b_next;
    logic              byp_a_next;
    logic              byp_b_next;
    logic [DATA_W-1:0] byp_val_a_next;
    logic [DATA_W-1:0] byp_val_b_next;

    assign accept_c  = (state == S_IDLE) && rd_req_ready && rd_req_valid;
    assign wb_fire_c = wb_valid && wb_ready;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept_c) state_next = S_SAMPLE;
            S_SAMPLE:  state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_HOLD;
            S_HOLD:    if (op_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Next values of the registered fetch outputs and bypass capture
    always_comb begin
        rd_req_ready_next = (state_next == S_IDLE);
        op_valid_next     = op_valid;
        op_a_next         = op_a;
        op_b_next         = op_b;
        rd_addr_a_next    = rf_readA_address;
        rd_addr_b_next    = rf_readB_address;
        byp_a_next        = byp_a;
        byp_b_next        = byp_b;
        byp_val_a_next    = byp_val_a;
        byp_val_b_next    = byp_val_b;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    rd_addr_a_next = rd_addr_a;
                    rd_addr_b_next = rd_addr_b;
                end
            end
            S_SAMPLE: begin
                // The RF returns the old value when a write shares the sample edge
                byp_a_next     = rf_write && (rf_write_address == rf_readA_address);
                byp_b_next     = rf_write && (rf_write_address == rf_readB_address);
                byp_val_a_next = rf_write_value;
                byp_val_b_next = rf_write_value;
            end
            S_CAPTURE: begin
                op_valid_next = 1'b1;
                op_a_next     = byp_a ? byp_val_a : rf_reg_A;
                op_b_next     = byp_b ? byp_val_b : rf_reg_B;
            end
            S_HOLD: begin
                if (op_ready) op_valid_next = 1'b0;
            end
            default: ;
        endcase
    end

    // Fetch output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_req_ready     <= 1'b0;
            op_valid         <= 1'b0;
            op_a             <= DATA_W'(0);
            op_b             <= DATA_W'(0);
            rf_readA_address <= ADDR_W'(0);
            rf_readB_address <= ADDR_W'(0);
            byp_a            <= 1'b0;
            byp_b            <= 1'b0;
            byp_val_a        <= DATA_W'(0);
            byp_val_b        <= DATA_W'(0);
        end else begin
            rd_req_ready     <= rd_req_ready_next;
            op_valid         <= op_valid_next;
            op_a             <= op_a_next;
            op_b             <= op_b_next;
            rf_readA_address <= rd_addr_a_next;
            rf_readB_address <= rd_addr_b_next;
            byp_a            <= byp_a_next;
            byp_b            <= byp_b_next;
            byp_val_a        <= byp_val_a_next;
            byp_val_b        <= byp_val_b_next;
        end
    end

    // Writeback path: one rf_write pulse per accepted wb_valid cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_ready         <= 1'b0;
            rf_write         <= 1'b0;
            rf_write_address <= ADDR_W'(0);
            rf_write_value   <= DATA_W'(0);
        end else begin
            wb_ready <= 1'b1;
            rf_write <= wb_fire_c;
            if (wb_fire_c) begin
                rf_write_address <= wb_addr;
                rf_write_value   <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: register-file model, directed scenarios
// and a randomized run checked against a timestamped write-log reference.
module tb_regfile_access_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic          CLK;
    logic          RST_N;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_readA_address;
    logic [AW-1:0] rf_readB_address;
    logic          rf_write;
    logic [AW-1:0] rf_write_address;
    logic [DW-1:0] rf_write_value;
    logic [DW-1:0] rf_reg_A;
    logic [DW-1:0] rf_reg_B;

    int total;
    int bad;
    int edge_n;
    int acc_edge;
    bit last_acc;
    logic [AW-1:0] pend_a;
    logic [AW-1:0] pend_b;

    // Reference: every accepted write, stamped with the edge that accepted it
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            log_edge[$];

    logic [DW-1:0] rf_mem [8];

    regfile_access_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .rd_req_valid     (rd_req_valid),
        .rd_req_ready     (rd_req_ready),
        .rd_addr_a        (rd_addr_a),
        .rd_addr_b        (rd_addr_b),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_a             (op_a),
        .op_b             (op_b),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .rf_readA_address (rf_readA_address),
        .rf_readB_address (rf_readB_address),
        .rf_write         (rf_write),
        .rf_write_address (rf_write_address),
        .rf_write_value   (rf_write_value),
        .rf_reg_A         (rf_reg_A),
        .rf_reg_B         (rf_reg_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: synchronous reads return the pre-write value
    always @(posedge CLK) begin
        rf_reg_A <= rf_mem[rf_readA_address];
        rf_reg_B <= rf_mem[rf_readB_address];
        if (rf_write === 1'b1) rf_mem[rf_write_address] <= rf_write_value;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    // A fetch sees every write accepted at or before its own acceptance edge
    function automatic logic [DW-1:0] model_val(input logic [AW-1:0] a, input int at);
        logic [DW-1:0] v;
        v = 'x;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] == a && log_edge[i] <= at) v = log_data[i];
        return v;
    endfunction

    task automatic step();
        logic acc_r;
        logic acc_w;
        acc_r = (rd_req_valid === 1'b1) && (rd_req_ready === 1'b1);
        acc_w = (wb_valid === 1'b1) && (wb_ready === 1'b1);
        @(posedge CLK);
        if (acc_w) begin
            log_addr.push_back(wb_addr);
            log_data.push_back(wb_data);
            log_edge.push_back(edge_n);
        end
        last_acc = acc_r;
        if (acc_r) begin
            acc_edge = edge_n;
            pend_a   = rd_addr_a;
            pend_b   = rd_addr_b;
        end
        edge_n++;
        #1;
    endtask

    task automatic run_fetch(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                             input string tag);
        int waitc;
        waitc = 0;
        rd_req_valid = 1'b0;
        while (rd_req_ready !== 1'b1 && waitc < 8) begin
            step();
            waitc++;
        end
        total++;
        if (rd_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: rd_req_ready=%b expected 1", tag, rd_req_ready);
        end
        rd_req_valid = 1'b1;
        rd_addr_a    = a;
        rd_addr_b    = b;
        step();
        rd_req_valid = 1'b0;
        total++;
        if (op_valid !== 1'b0 || rf_readA_address !== a || rf_readB_address !== b) begin
            bad++;
            $display("FAIL %s_sample: op_valid=%b addrA=%0d addrB=%0d expected 0 %0d %0d",
                     tag, op_valid, rf_readA_address, rf_readB_address, a, b);
        end
        step();
        total++;
        if (op_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_early: op_valid=%b expected 0", tag, op_valid);
        end
        step();
        total++;
        if (op_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_latency: op_valid=%b expected 1", tag, op_valid);
        end
        total++;
        if (op_a !== ea) begin
            bad++;
            $display("FAIL %s_op_a: got %h expected %h", tag, op_a, ea);
        end
        total++;
        if (op_b !== eb) begin
            bad++;
            $display("FAIL %s_op_b: got %h expected %h", tag, op_b, eb);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        total++;
        if (op_valid !== 1'b0 || rd_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_release: op_valid=%b rd_req_ready=%b expected 0 1",
                     tag, op_valid, rd_req_ready);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        rd_req_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        #2 RST_N = 1'b0;
        #1;
        total++;
        if ({op_valid, rf_write, rd_req_ready, wb_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: {op_valid,rf_write,rd_req_ready,wb_ready}=%b expected 0000",
                     {op_valid, rf_write, rd_req_ready, wb_ready});
        end
        total++;
        if ({op_a, op_b, rf_write_value} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data: op_a=%h op_b=%h wval=%h expected 0", op_a, op_b, rf_write_value);
        end
        total++;
        if ({rf_readA_address, rf_readB_address, rf_write_address} !== 9'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h expected 0",
                     {rf_readA_address, rf_readB_address, rf_write_address});
        end
        step();
        step();
        total++;
        if (rd_req_ready !== 1'b0 || wb_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: rd_req_ready=%b wb_ready=%b expected 0 0", rd_req_ready, wb_ready);
        end
        RST_N = 1'b1;
        step();
        total++;
        if (rd_req_ready !== 1'b1 || wb_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: rd_req_ready=%b wb_ready=%b expected 1 1", rd_req_ready, wb_ready);
        end
    endtask

    task automatic test_basic();
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        step();
        total++;
        if (rf_write !== 1'b1 || rf_write_address !== 3'd3 || rf_write_value !== 16'h1234) begin
            bad++;
            $display("FAIL basic_wb0: we=%b a=%0d v=%h expected 1 3 1234", rf_write, rf_write_address, rf_write_value);
        end
        wb_addr = 3'd5; wb_data = 16'hBEEF;
        step();
        total++;
        if (rf_write !== 1'b1 || rf_write_address !== 3'd5 || rf_write_value !== 16'hBEEF) begin
            bad++;
            $display("FAIL basic_wb1: we=%b a=%0d v=%h expected 1 5 beef", rf_write, rf_write_address, rf_write_value);
        end
        wb_valid = 1'b0;
        step();
        total++;
        if (rf_write !== 1'b0) begin
            bad++;
            $display("FAIL basic_wb_end: rf_write=%b expected 0", rf_write);
        end
        run_fetch(3'd3, 3'd5, 16'h1234, 16'hBEEF, "basic");
    endtask

    task automatic test_hold();
        rd_req_valid = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        step();
        rd_req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (op_valid !== 1'b1 || op_a !== 16'h1234 || op_b !== 16'hBEEF || rd_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: v=%b a=%h b=%h rdy=%b expected 1 1234 beef 0",
                         i, op_valid, op_a, op_b, rd_req_ready);
            end
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        total++;
        if (op_valid !== 1'b0 || rd_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: op_valid=%b rd_req_ready=%b expected 0 1", op_valid, rd_req_ready);
        end
    endtask

    task automatic test_bypass_sample();
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001;
        step();
        wb_valid = 1'b0;
        step();
        rd_req_valid = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AA;
        step();
        rd_req_valid = 1'b0; wb_valid = 1'b0;
        total++;
        if (rf_write !== 1'b1) begin
            bad++;
            $display("FAIL byp_s_pulse: rf_write=%b expected 1", rf_write);
        end
        step();
        step();
        total++;
        if (op_valid !== 1'b1 || op_a !== 16'h00AA || op_b !== 16'h00AA) begin
            bad++;
            $display("FAIL byp_sample: v=%b a=%h b=%h expected 1 00aa 00aa", op_valid, op_a, op_b);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_bypass_capture();
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001;
        step();
        wb_valid = 1'b0;
        step();
        rd_req_valid = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        step();
        rd_req_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AA;
        step();
        wb_valid = 1'b0;
        total++;
        if (rf_write !== 1'b1) begin
            bad++;
            $display("FAIL byp_c_pulse: rf_write=%b expected 1", rf_write);
        end
        step();
        total++;
        if (op_valid !== 1'b1 || op_a !== 16'h0001 || op_b !== 16'h0001) begin
            bad++;
            $display("FAIL byp_capture: v=%b a=%h b=%h expected 1 0001 0001", op_valid, op_a, op_b);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        run_fetch(3'd2, 3'd2, 16'h00AA, 16'h00AA, "after_capture");
    endtask

    task automatic test_reset_mid();
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001;
        step();
        wb_valid = 1'b0;
        step();
        rd_req_valid = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h00FF;
        step();
        rd_req_valid = 1'b0; wb_valid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        total++;
        if (rf_write !== 1'b0 || op_valid !== 1'b0 || rd_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: we=%b v=%b rdy=%b expected 0 0 0", rf_write, op_valid, rd_req_ready);
        end
        // The write was still pending in the sequencer, so it never reaches the RF
        if (log_addr.size() > 0) begin
            void'(log_addr.pop_back());
            void'(log_data.pop_back());
            void'(log_edge.pop_back());
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (op_valid !== 1'b0 || rf_write !== 1'b0) begin
                bad++;
                $display("FAIL rst_hold_%0d: op_valid=%b rf_write=%b expected 0 0", i, op_valid, rf_write);
            end
        end
        RST_N = 1'b1;
        step();
        total++;
        if (rd_req_ready !== 1'b1 || op_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: rd_req_ready=%b op_valid=%b expected 1 0", rd_req_ready, op_valid);
        end
        run_fetch(3'd2, 3'd2, 16'h0001, 16'h0001, "after_reset");
    endtask

    task automatic test_all_regs();
        logic [AW-1:0] ia;
        logic [AW-1:0] ib;
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_addr = AW'(i); wb_data = DW'(16'h1000 + i);
            step();
            total++;
            if (rf_write !== 1'b1 || rf_write_address !== AW'(i) || rf_write_value !== DW'(16'h1000 + i)) begin
                bad++;
                $display("FAIL b2b_wb_%0d: we=%b a=%0d v=%h expected 1 %0d %h",
                         i, rf_write, rf_write_address, rf_write_value, i, DW'(16'h1000 + i));
            end
        end
        wb_valid = 1'b0;
        step();
        total++;
        if (rf_write !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wb_end: rf_write=%b expected 0", rf_write);
        end
        ia = '0;
        for (int i = 0; i < 8; i++) begin
            ib = AW'(7) - ia;
            run_fetch(ia, ib, DW'(16'h1000 + i), DW'(16'h1007 - i), "b2b_fetch");
            ia = ia + AW'(1);
        end
    endtask

    task automatic test_random();
        bit            busy;
        bit            rel;
        int            since;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        busy = 1'b0;
        since = 0;
        ea = '0;
        eb = '0;
        for (int c = 0; c < 600; c++) begin
            wb_valid     = 1'($urandom_range(0, 1));
            wb_addr      = AW'($urandom);
            wb_data      = DW'($urandom);
            rd_req_valid = 1'($urandom_range(0, 1));
            rd_addr_a    = AW'($urandom);
            rd_addr_b    = AW'($urandom);
            op_ready     = ($urandom_range(0, 2) == 0);
            rel = busy && (op_valid === 1'b1) && op_ready;
            step();
            if (rel) begin
                busy = 1'b0;
                total++;
                if (op_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_release c=%0d: op_valid=%b expected 0", c, op_valid);
                end
            end else if (last_acc) begin
                busy = 1'b1;
                since = 0;
                ea = model_val(pend_a, acc_edge);
                eb = model_val(pend_b, acc_edge);
                total++;
                if (op_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_accept c=%0d: op_valid=%b expected 0", c, op_valid);
                end
            end else if (busy) begin
                since++;
                total++;
                if (since < 2 && op_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_early c=%0d: op_valid=%b expected 0", c, op_valid);
                end else if (since >= 2 && (op_valid !== 1'b1 || op_a !== ea || op_b !== eb)) begin
                    bad++;
                    $display("FAIL rnd_operands c=%0d: v=%b a=%h b=%h expected 1 %h %h",
                             c, op_valid, op_a, op_b, ea, eb);
                end
                total++;
                if (rd_req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_busy_ready c=%0d: rd_req_ready=%b expected 0", c, rd_req_ready);
                end
            end
        end
        wb_valid = 1'b0;
        rd_req_valid = 1'b0;
        op_ready = 1'b1;
        step();
        step();
        op_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        edge_n = 0;
        acc_edge = 0;
        last_acc = 1'b0;
        pend_a = '0;
        pend_b = '0;
        test_reset();
        test_basic();
        test_hold();
        test_bypass_sample();
        test_bypass_capture();
        test_reset_mid();
        test_all_regs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
